// File: rtl/sd_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sd_init_sequencer
// Purpose  : Runs the SD-card SPI-mode initialisation sequence (CMD0, CMD8,
//            CMD55/ACMD41 loop, CMD58) through a 48-bit spi_master. Each
//            command frame is sent, the R1 byte is polled with all-ones frames,
//            and R1/R7/OCR are decoded into card type and capacity class.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            init_start          - pulse, starts a sequence from IDLE/DONE/ERR
//            init_busy           - sequence in progress
//            init_done/init_error- terminal status levels
//            err_code[2:0]       - 1 CMD0, 2 CMD8, 3 ACMD41, 4 CMD58,
//                                  5 response timeout, 6 CMD55
//            card_v2, card_ccs   - decoded card type / capacity class
//            spi_start, spi_write_data[47:0] - transfer request to spi_master
//            spi_read_data[47:0], spi_done   - transfer result from spi_master
// Revision : 1.0 - initial release
// ============================================================================
module sd_init_sequencer #(
  parameter int MAX_POLL   = 8,
  parameter int MAX_ACMD41 = 1000,
  parameter int CNT_W      = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_start,
  output logic        init_busy,
  output logic        init_done,
  output logic        init_error,
  output logic [2:0]  err_code,
  output logic        card_v2,
  output logic        card_ccs,
  output logic        spi_start,
  output logic [47:0] spi_write_data,
  input  logic [47:0] spi_read_data,
  input  logic        spi_done
);

  // Poll counter must be able to hold MAX_POLL itself.
  localparam int PW = $clog2(MAX_POLL + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_CHECK   = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [2:0] S_ERR     = 3'd6;

  localparam logic [2:0] C_CMD0    = 3'd0;
  localparam logic [2:0] C_CMD8    = 3'd1;
  localparam logic [2:0] C_CMD55   = 3'd2;
  localparam logic [2:0] C_ACMD41  = 3'd3;
  localparam logic [2:0] C_CMD58   = 3'd4;

  localparam logic [47:0] C_FRM_POLL   = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] C_FRM_CMD0   = 48'h400000000095;
  localparam logic [47:0] C_FRM_CMD8   = 48'h48000001AA87;
  localparam logic [47:0] C_FRM_CMD55  = 48'h770000000065;
  localparam logic [47:0] C_FRM_A41_HC = 48'h694000000077;
  localparam logic [47:0] C_FRM_A41_SC = 48'h6900000000E5;
  localparam logic [47:0] C_FRM_CMD58  = 48'h7A00000000FD;

  localparam logic [2:0] C_ERR_NONE  = 3'd0;
  localparam logic [2:0] C_ERR_CMD0  = 3'd1;
  localparam logic [2:0] C_ERR_CMD8  = 3'd2;
  localparam logic [2:0] C_ERR_A41   = 3'd3;
  localparam logic [2:0] C_ERR_CMD58 = 3'd4;
  localparam logic [2:0] C_ERR_RSP   = 3'd5;
  localparam logic [2:0] C_ERR_CMD55 = 3'd6;

  logic [2:0]       r_state, w_state;
  logic [2:0]       r_cmd,   w_cmd;
  logic [PW-1:0]    r_poll,  w_poll;
  logic [CNT_W-1:0] r_acmd,  w_acmd;
  logic [47:0]      r_rsp,   w_rsp;
  logic [47:0]      r_tx,    w_tx;
  logic [2:0]       r_err,   w_err;
  logic             r_v2,    w_v2;
  logic             r_ccs,   w_ccs;

  logic [7:0]       w_r1;
  logic [PW-1:0]    w_poll_inc;
  logic [CNT_W:0]   w_acmd_inc;
  logic             w_unused;

  // Frame for the next transfer: a poll frame while still waiting for R1 of
  // the current command, otherwise the command itself. ACMD41 advertises HCS
  // only to cards that answered CMD8.
  function automatic logic [47:0] frame_of(input logic [2:0] cmd,
                                           input logic       poll,
                                           input logic       v2);
    logic [47:0] f;
    f = C_FRM_POLL;
    if (!poll) begin
      case (cmd)
        C_CMD0:   f = C_FRM_CMD0;
        C_CMD8:   f = C_FRM_CMD8;
        C_CMD55:  f = C_FRM_CMD55;
        C_ACMD41: f = v2 ? C_FRM_A41_HC : C_FRM_A41_SC;
        C_CMD58:  f = C_FRM_CMD58;
        default:  f = C_FRM_POLL;
      endcase
    end
    return f;
  endfunction

  assign w_r1       = r_rsp[47:40];
  assign w_poll_inc = r_poll + 1'b1;
  assign w_acmd_inc = {1'b0, r_acmd} + 1'b1;
  // Response bits that carry nothing this block decodes.
  assign w_unused   = ^{r_rsp[39], r_rsp[37:20], r_rsp[7:0]};

  always_comb begin
    w_state = r_state;
    w_cmd   = r_cmd;
    w_poll  = r_poll;
    w_acmd  = r_acmd;
    w_rsp   = r_rsp;
    w_err   = r_err;
    w_v2    = r_v2;
    w_ccs   = r_ccs;

    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (init_start) begin
          w_state = S_ISSUE;
          w_cmd   = C_CMD0;
          w_poll  = '0;
          w_acmd  = '0;
          w_err   = C_ERR_NONE;
          w_v2    = 1'b0;
          w_ccs   = 1'b0;
        end
      end
      S_ISSUE: w_state = S_WAIT;
      S_WAIT: begin
        if (spi_done) begin
          w_rsp   = spi_read_data;
          w_state = S_RELEASE;
        end
      end
      // A level-style done must drop before the next request can go out.
      S_RELEASE: begin
        if (!spi_done) w_state = S_CHECK;
      end
      S_CHECK: begin
        if (w_r1 == 8'hFF) begin
          w_poll = w_poll_inc;
          if (w_poll_inc == PW'(MAX_POLL)) begin
            w_state = S_ERR;
            w_err   = C_ERR_RSP;
          end else begin
            w_state = S_ISSUE;
          end
        end else begin
          w_poll  = '0;
          w_state = S_ISSUE;
          case (r_cmd)
            C_CMD0: begin
              if (w_r1 == 8'h01) w_cmd = C_CMD8;
              else begin w_state = S_ERR; w_err = C_ERR_CMD0; end
            end
            C_CMD8: begin
              if (w_r1 == 8'h01 && r_rsp[19:8] == 12'h1AA) begin
                w_v2  = 1'b1;
                w_cmd = C_CMD55;
              end else if (w_r1 == 8'h05) begin
                w_v2  = 1'b0;
                w_cmd = C_CMD55;
              end else begin
                w_state = S_ERR;
                w_err   = C_ERR_CMD8;
              end
            end
            C_CMD55: begin
              if (w_r1 == 8'h00 || w_r1 == 8'h01) w_cmd = C_ACMD41;
              else begin w_state = S_ERR; w_err = C_ERR_CMD55; end
            end
            C_ACMD41: begin
              if (w_r1 == 8'h00) begin
                if (r_v2) w_cmd = C_CMD58;
                else      w_state = S_DONE;
              end else if (w_r1 == 8'h01) begin
                // Saturating count of "still idle" answers.
                if (!(&r_acmd)) w_acmd = w_acmd_inc[CNT_W-1:0];
                if (w_acmd_inc >= (CNT_W+1)'(MAX_ACMD41)) begin
                  w_state = S_ERR;
                  w_err   = C_ERR_A41;
                end else begin
                  w_cmd = C_CMD55;
                end
              end else begin
                w_state = S_ERR;
                w_err   = C_ERR_A41;
              end
            end
            C_CMD58: begin
              if (w_r1 == 8'h00) begin
                w_ccs   = r_rsp[38];
                w_state = S_DONE;
              end else begin
                w_state = S_ERR;
                w_err   = C_ERR_CMD58;
              end
            end
            default: w_state = S_IDLE;
          endcase
        end
      end
      default: w_state = S_IDLE;
    endcase

    // Frame is registered on entry to ISSUE and stays put for the transfer.
    w_tx = (w_state == S_ISSUE) ? frame_of(w_cmd, (w_poll != '0), w_v2) : r_tx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cmd   <= C_CMD0;
      r_poll  <= '0;
      r_acmd  <= '0;
      r_rsp   <= '0;
      r_tx    <= C_FRM_POLL;
      r_err   <= C_ERR_NONE;
      r_v2    <= 1'b0;
      r_ccs   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cmd   <= w_cmd;
      r_poll  <= w_poll;
      r_acmd  <= w_acmd;
      r_rsp   <= w_rsp;
      r_tx    <= w_tx;
      r_err   <= w_err;
      r_v2    <= w_v2;
      r_ccs   <= w_ccs;
    end
  end

  assign spi_start      = (r_state == S_ISSUE);
  assign spi_write_data = r_tx;
  assign init_busy      = (r_state == S_ISSUE) || (r_state == S_WAIT) ||
                          (r_state == S_RELEASE) || (r_state == S_CHECK);
  assign init_done      = (r_state == S_DONE);
  assign init_error     = (r_state == S_ERR);
  assign err_code       = r_err;
  assign card_v2        = r_v2;
  assign card_ccs       = r_ccs;

endmodule
`default_nettype wire

// File: tb/tb_sd_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_init_sequencer
// Purpose  : Self-checking bench for sd_init_sequencer. A scripted SPI slave
//            answers each transfer; expected frames and responses are queued
//            per scenario and consumed as the DUT issues spi_start.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_init_sequencer;

  localparam logic [47:0] F_POLL   = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] F_CMD0   = 48'h400000000095;
  localparam logic [47:0] F_CMD8   = 48'h48000001AA87;
  localparam logic [47:0] F_CMD55  = 48'h770000000065;
  localparam logic [47:0] F_A41_HC = 48'h694000000077;
  localparam logic [47:0] F_A41_SC = 48'h6900000000E5;
  localparam logic [47:0] F_CMD58  = 48'h7A00000000FD;

  logic        clk;
  logic        rst_n;
  logic        init_start;
  logic        init_busy;
  logic        init_done;
  logic        init_error;
  logic [2:0]  err_code;
  logic        card_v2;
  logic        card_ccs;
  logic        spi_start;
  logic [47:0] spi_write_data;
  logic [47:0] spi_read_data;
  logic        spi_done;

  int n_cmp = 0;
  int n_err = 0;

  logic [47:0] exp_q[$];
  logic [47:0] rsp_q[$];
  int          hold_q[$];

  sd_init_sequencer #(
    .MAX_POLL   (8),
    .MAX_ACMD41 (4),
    .CNT_W      (10)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .init_start     (init_start),
    .init_busy      (init_busy),
    .init_done      (init_done),
    .init_error     (init_error),
    .err_code       (err_code),
    .card_v2        (card_v2),
    .card_ccs       (card_ccs),
    .spi_start      (spi_start),
    .spi_write_data (spi_write_data),
    .spi_read_data  (spi_read_data),
    .spi_done       (spi_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] r1_rsp(input logic [7:0] r1);
    return {r1, 40'hFFFFFFFFFF};
  endfunction

  task automatic push(input logic [47:0] frame, input logic [47:0] rsp, input int hold);
    exp_q.push_back(frame);
    rsp_q.push_back(rsp);
    hold_q.push_back(hold);
  endtask

  task automatic start_seq();
    @(negedge clk);
    init_start = 1'b1;
    @(negedge clk);
    init_start = 1'b0;
  endtask

  // Serve every queued transfer: check the frame, answer after a short delay
  // with spi_done held for the queued number of cycles.
  task automatic run_slave();
    logic [47:0] exp_frm;
    logic [47:0] rsp;
    int          hold;
    int          guard;
    int          early;
    while (exp_q.size() > 0) begin
      guard = 0;
      while (!spi_start && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (!spi_start) begin
        check("start_wait", 48'(spi_start), 48'(1));
        exp_q.delete();
        rsp_q.delete();
        hold_q.delete();
        return;
      end
      exp_frm = exp_q.pop_front();
      rsp     = rsp_q.pop_front();
      hold    = hold_q.pop_front();
      check("frame", spi_write_data, exp_frm);
      check("busy_in_xfer", 48'(init_busy), 48'(1));
      @(negedge clk);
      check("start_one_cycle", 48'(spi_start), 48'(0));
      @(negedge clk);
      check("frame_stable", spi_write_data, exp_frm);
      spi_read_data = rsp;
      spi_done      = 1'b1;
      early = 0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (spi_start) early++;
      end
      if (hold > 1) check("no_start_while_done", 48'(early), 48'(0));
      spi_done      = 1'b0;
      spi_read_data = 48'h0;
    end
  endtask

  task automatic expect_status(input string tag, input logic done, input logic err,
                               input logic [2:0] code, input logic v2, input logic ccs);
    int guard;
    int extra;
    guard = 0;
    while (init_busy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_busy"},  48'(init_busy),  48'(0));
    check({tag, "_done"},  48'(init_done),  48'(done));
    check({tag, "_error"}, 48'(init_error), 48'(err));
    check({tag, "_code"},  48'(err_code),   48'(code));
    check({tag, "_v2"},    48'(card_v2),    48'(v2));
    check({tag, "_ccs"},   48'(card_ccs),   48'(ccs));
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (spi_start) extra++;
    end
    check({tag, "_extra_start"}, 48'(extra), 48'(0));
  endtask

  task automatic queue_v1_quick();
    push(F_CMD0,   r1_rsp(8'h01), 1);
    push(F_CMD8,   r1_rsp(8'h05), 1);
    push(F_CMD55,  r1_rsp(8'h01), 1);
    push(F_A41_SC, r1_rsp(8'h00), 1);
  endtask

  initial begin
    int guard;
    int extra;
    rst_n         = 1'b0;
    init_start    = 1'b0;
    spi_done      = 1'b0;
    spi_read_data = 48'h0;
    repeat (3) @(negedge clk);
    check("rst_start", 48'(spi_start),  48'(0));
    check("rst_wdata", spi_write_data,  F_POLL);
    check("rst_busy",  48'(init_busy),  48'(0));
    check("rst_done",  48'(init_done),  48'(0));
    check("rst_error", 48'(init_error), 48'(0));
    check("rst_code",  48'(err_code),   48'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // v2 high-capacity card; CMD0 answer held as a 5-cycle level.
    start_seq();
    push(F_CMD0,   r1_rsp(8'h01), 5);
    push(F_CMD8,   {8'h01, 32'h000001AA, 8'hFF}, 1);
    push(F_CMD55,  r1_rsp(8'h01), 1);
    push(F_A41_HC, r1_rsp(8'h01), 1);
    push(F_CMD55,  r1_rsp(8'h01), 1);
    push(F_A41_HC, r1_rsp(8'h01), 1);
    push(F_CMD55,  r1_rsp(8'h01), 1);
    push(F_A41_HC, r1_rsp(8'h00), 1);
    push(F_CMD58,  {8'h00, 32'hC0FF8000, 8'hFF}, 2);
    run_slave();
    expect_status("v2", 1'b1, 1'b0, 3'd0, 1'b1, 1'b1);

    // v1 card: CMD8 illegal, ready on first ACMD41, no CMD58.
    start_seq();
    queue_v1_quick();
    run_slave();
    expect_status("v1", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);

    // Three poll frames before CMD0 answers.
    start_seq();
    push(F_CMD0,  r1_rsp(8'hFF), 1);
    push(F_POLL,  r1_rsp(8'hFF), 1);
    push(F_POLL,  r1_rsp(8'hFF), 1);
    push(F_POLL,  r1_rsp(8'h01), 1);
    push(F_CMD8,  r1_rsp(8'h05), 1);
    push(F_CMD55, r1_rsp(8'h00), 1);
    push(F_A41_SC, r1_rsp(8'h00), 1);
    run_slave();
    expect_status("poll3", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);

    // All-ones for MAX_POLL frames: command plus seven polls.
    start_seq();
    push(F_CMD0, r1_rsp(8'hFF), 1);
    for (int i = 0; i < 7; i++) push(F_POLL, r1_rsp(8'hFF), 1);
    run_slave();
    expect_status("poll_to", 1'b0, 1'b1, 3'd5, 1'b0, 1'b0);

    // ACMD41 never leaves idle: four CMD55/ACMD41 pairs then timeout.
    start_seq();
    push(F_CMD0, r1_rsp(8'h01), 1);
    push(F_CMD8, {8'h01, 32'h000001AA, 8'hFF}, 1);
    for (int i = 0; i < 4; i++) begin
      push(F_CMD55,  r1_rsp(8'h01), 1);
      push(F_A41_HC, r1_rsp(8'h01), 1);
    end
    run_slave();
    expect_status("a41_to", 1'b0, 1'b1, 3'd3, 1'b1, 1'b0);

    // Bad CMD8 echo, then a clean restart.
    start_seq();
    push(F_CMD0, r1_rsp(8'h01), 1);
    push(F_CMD8, {8'h01, 32'h000000AA, 8'hFF}, 1);
    run_slave();
    expect_status("bad_echo", 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
    start_seq();
    queue_v1_quick();
    run_slave();
    expect_status("restart", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);

    // CMD0 rejected.
    start_seq();
    push(F_CMD0, r1_rsp(8'h00), 1);
    run_slave();
    expect_status("cmd0_bad", 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);

    // CMD58 rejected after a v2 handshake.
    start_seq();
    push(F_CMD0,   r1_rsp(8'h01), 1);
    push(F_CMD8,   {8'h01, 32'h000001AA, 8'hFF}, 1);
    push(F_CMD55,  r1_rsp(8'h00), 1);
    push(F_A41_HC, r1_rsp(8'h00), 1);
    push(F_CMD58,  r1_rsp(8'h09), 1);
    run_slave();
    expect_status("cmd58_bad", 1'b0, 1'b1, 3'd4, 1'b1, 1'b0);

    // CMD55 rejected.
    start_seq();
    push(F_CMD0,  r1_rsp(8'h01), 1);
    push(F_CMD8,  r1_rsp(8'h05), 1);
    push(F_CMD55, r1_rsp(8'h04), 1);
    run_slave();
    expect_status("cmd55_bad", 1'b0, 1'b1, 3'd6, 1'b0, 1'b0);

    // Reset while CMD8 transfer is outstanding.
    start_seq();
    push(F_CMD0, r1_rsp(8'h01), 1);
    run_slave();
    guard = 0;
    while (!spi_start && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("mid_cmd8_frame", spi_write_data, F_CMD8);
    @(negedge clk);
    check("mid_busy", 48'(init_busy), 48'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_start", 48'(spi_start),  48'(0));
    check("mid_rst_busy",  48'(init_busy),  48'(0));
    check("mid_rst_wdata", spi_write_data,  F_POLL);
    check("mid_rst_done",  48'(init_done),  48'(0));
    check("mid_rst_error", 48'(init_error), 48'(0));
    check("mid_rst_code",  48'(err_code),   48'(0));
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (spi_start) extra++;
    end
    check("mid_rst_no_start", 48'(extra), 48'(0));
    start_seq();
    queue_v1_quick();
    run_slave();
    expect_status("post_rst", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
